// File: rtl/smg_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner:
// the hex-to-segment table, the blank segment pattern, the active-low select levels
// and the slot phase type.
package smg_pkg;

    // Segment bus pattern with every segment and the decimal point dark.
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Digit selects are active-low.
    localparam logic SEL_ON  = 1'b0;
    localparam logic SEL_OFF = 1'b1;

    // A digit slot opens with a ghost-suppression gap, then drives the digit.
    typedef enum logic {
        PH_GAP    = 1'b0,
        PH_ACTIVE = 1'b1
    } slot_phase_e;

    // Hex digit to active-high segments {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg7(input logic [3:0] hex);
        logic [6:0] segs;
        case (hex)
            4'h0: segs = 7'h3F;
            4'h1: segs = 7'h06;
            4'h2: segs = 7'h5B;
            4'h3: segs = 7'h4F;
            4'h4: segs = 7'h66;
            4'h5: segs = 7'h6D;
            4'h6: segs = 7'h7D;
            4'h7: segs = 7'h07;
            4'h8: segs = 7'h7F;
            4'h9: segs = 7'h6F;
            4'hA: segs = 7'h77;
            4'hB: segs = 7'h7C;
            4'hC: segs = 7'h39;
            4'hD: segs = 7'h5E;
            4'hE: segs = 7'h79;
            default: segs = 7'h71;
        endcase
        return segs;
    endfunction

endpackage

// File: rtl/smg_hex2seg_funcmod.sv
// Combinational decode of one hex nibble into active-high seven-segment levels.
module smg_hex2seg_funcmod
    import smg_pkg::*;
(
    input  logic [3:0] iHex,
    output logic [6:0] oSeg7
);

    assign oSeg7 = seg7(iHex);

endmodule

// File: rtl/smg_scan_funcmod.sv
// Multiplexed seven-segment scanner: time-slices NDIG hex digits onto one shared,
// active-low segment bus with active-low digit selects. Each slot opens with a
// ghost-suppression gap; the inputs are snapshotted once per frame so a frame never
// tears. Supports decimal points, per-digit blanking and leading-zero suppression.
// Optional feature macro: SMG_DIM_EN adds the iDuty port and a free-running 4-bit
// brightness counter that gates the selects inside the active window.
module smg_scan_funcmod
    import smg_pkg::*;
#(
    parameter int NDIG   = 6,
    parameter int T_SLOT = 5000,
    parameter int T_GAP  = 50
) (
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic [4*NDIG-1:0]   iData,
    input  logic [NDIG-1:0]     iDp,
    input  logic [NDIG-1:0]     iBlank,
    input  logic                iLZ,
`ifdef SMG_DIM_EN
    input  logic [3:0]          iDuty,
`endif
    output logic [7:0]          oSeg,
    output logic [NDIG-1:0]     oSel,
    output logic [4+NDIG-1:0]   oData,
    output logic                oFrame
);

    localparam int CW = $clog2(T_SLOT);
    localparam int IW = $clog2(NDIG);

    localparam logic [CW-1:0] C1_LAST = CW'(T_SLOT - 1);
    localparam logic [CW-1:0] C1_GAP  = CW'(T_GAP);
    localparam logic [IW-1:0] I_LAST  = IW'(NDIG - 1);

    // Slot counter and digit index.
    logic [CW-1:0]      c1_q, c1_d;
    logic [IW-1:0]      i_q, i_d;

    // Per-frame snapshot of the display inputs.
    logic [4*NDIG-1:0]  snap_data_q;
    logic [NDIG-1:0]    snap_dp_q;
    logic [NDIG-1:0]    snap_blank_q;
    logic               snap_lz_q;
    logic               snap_load;

    // Output registers.
    logic [7:0]         seg_q, seg_d;
    logic [NDIG-1:0]    sel_q, sel_d;
    logic [3:0]         nib_q, nib_d;
    logic               frame_q, frame_d;

    // Decode of the digit currently addressed by i_q.
    logic [3:0]         digit [NDIG];
    logic [NDIG-1:0]    lead_zero;
    logic [3:0]         cur_nib;
    logic               cur_dp;
    logic               cur_blank;
    logic [6:0]         seg7_raw;
    slot_phase_e        phase;
    logic               lamp_on;

`ifdef SMG_DIM_EN
    logic [3:0]         p_q;

    // Free-running brightness phase; the select is lit while the phase is at or below iDuty.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            p_q <= 4'h0;
        end else begin
            p_q <= p_q + 4'h1;
        end
    end

    assign lamp_on = (p_q <= iDuty);
`else
    assign lamp_on = 1'b1;
`endif

    // Unpack the snapshot, find the leading-zero run and select the current digit.
    always_comb begin
        // NOTE: every variable written here gets a value on every path, so no latch is inferred.
        for (int k = 0; k < NDIG; k++) begin
            digit[k] = snap_data_q[4*(NDIG-1-k) +: 4];
        end
        lead_zero[0] = (digit[0] == 4'h0);
        for (int k = 1; k < NDIG; k++) begin
            lead_zero[k] = lead_zero[k-1] & (digit[k] == 4'h0);
        end
        cur_nib   = digit[i_q];
        cur_dp    = snap_dp_q[i_q];
        // The last digit is never suppressed, so an all-zero value still shows a single 0.
        cur_blank = snap_blank_q[i_q] | (snap_lz_q & lead_zero[i_q] & (i_q != I_LAST));
    end

    smg_hex2seg_funcmod u_hex2seg (
        .iHex  (cur_nib),
        .oSeg7 (seg7_raw)
    );

    // Counter advance, snapshot strobe and next values of the registered outputs.
    always_comb begin
        c1_d = c1_q + CW'(1);
        i_d  = i_q;
        if (c1_q == C1_LAST) begin
            c1_d = '0;
            i_d  = (i_q == I_LAST) ? '0 : i_q + IW'(1);
        end

        snap_load = (i_q == '0) && (c1_q == '0);

        phase = (c1_q < C1_GAP) ? PH_GAP : PH_ACTIVE;
        sel_d = {NDIG{SEL_OFF}};
        seg_d = SEG_OFF;
        if (phase == PH_ACTIVE) begin
            if (lamp_on) begin
                sel_d[i_q] = SEL_ON;
            end
            seg_d = ~{cur_dp, (cur_blank ? 7'h00 : seg7_raw)};
        end
        nib_d   = cur_nib;
        frame_d = (i_q == I_LAST) && (c1_q == C1_LAST);
    end

    // State and output registers; RESET aborts the frame and restarts at digit 0.
    always_ff @(posedge CLOCK) begin
        // NOTE: RESET is sampled on the clock edge, so it takes effect at the next rising edge.
        if (RESET) begin
            c1_q         <= '0;
            i_q          <= '0;
            snap_data_q  <= '0;
            snap_dp_q    <= '0;
            snap_blank_q <= '0;
            snap_lz_q    <= 1'b0;
            seg_q        <= SEG_OFF;
            sel_q        <= {NDIG{SEL_OFF}};
            nib_q        <= 4'h0;
            frame_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            c1_q <= c1_d;
            i_q  <= i_d;
            if (snap_load) begin
                snap_data_q  <= iData;
                snap_dp_q    <= iDp;
                snap_blank_q <= iBlank;
                snap_lz_q    <= iLZ;
            end
            seg_q   <= seg_d;
            sel_q   <= sel_d;
            nib_q   <= nib_d;
            frame_q <= frame_d;
        end
    end

    assign oSeg   = seg_q;
    assign oSel   = sel_q;
    assign oData  = {nib_q, sel_q};
    assign oFrame = frame_q;

endmodule
